// File: rtl/rep_string_sequencer.sv
// REP/REPE/REPNE string-iteration controller (decode stage 1).
// Holds one prefixed string instruction and reissues it once per iteration.
// Each issue writes the decremented count back. Iteration stops when the count
// runs out, or on a ZF condition for CMPS/SCAS. Interrupts are taken only
// between iterations. Non-REP instructions pass straight through.
module rep_string_sequencer #(
  parameter int CNT_W      = 32,
  parameter int OPC_W      = 16,
  parameter int ITER_BURST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [1:0]       in_rep,
  input  logic             in_addr16,
  input  logic [CNT_W-1:0] ecx_in,
  input  logic             pending_int,
  output logic             hold_int,
  output logic             int_yield,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] out_opcode,
  output logic             out_last,
  output logic             wb_valid,
  output logic [CNT_W-1:0] wb_data,
  output logic [2:0]       wb_size,
  input  logic             flag_valid,
  input  logic             flag_zf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ITER    = 2'd1;
  localparam logic [1:0] S_WAIT_ZF = 2'd2;
  localparam logic [3:0] BURST     = 4'(ITER_BURST);

  logic [1:0]       state_q;
  logic [OPC_W-1:0] opc_q;
  logic             repne_q;
  logic             a16_q;
  logic [CNT_W-17:0] ecx_hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       burst_q;

  logic             rep_none;
  logic             cond_op;
  logic             burst_sat;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_dec;
  logic [15:0]      cnt16_dec;
  logic [CNT_W-1:0] in_cnt;
  logic             fire;
  logic             yield;
  logic             zf_term;

  // Decode helpers. The count is kept zero-extended in 16-bit mode, so a plain
  // decrement never borrows into the upper bits (count is never 0 in ITER).
  assign rep_none  = (in_rep == 2'b00) || (in_rep == 2'b11);
  assign cond_op   = opc_q[OPC_W-1 -: 8] inside {8'hA6, 8'hA7, 8'hAE, 8'hAF};
  assign burst_sat = burst_q >= BURST;
  assign cnt_last  = cnt_q == CNT_W'(1);
  assign cnt_dec   = cnt_q - CNT_W'(1);
  assign cnt16_dec = cnt_q[15:0] - 16'd1;
  assign in_cnt    = in_addr16 ? {{(CNT_W-16){1'b0}}, ecx_in[15:0]} : ecx_in;
  assign fire      = out_valid & out_ready;
  // REPE stops on ZF=0, REPNE stops on ZF=1.
  assign zf_term   = repne_q ? flag_zf : ~flag_zf;

  // Output handshake, write-back and interrupt gating per state.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_opcode = opc_q;
    out_last   = 1'b0;
    hold_int   = 1'b0;
    int_yield  = 1'b0;
    yield      = 1'b0;
    wb_valid   = 1'b0;
    wb_data    = a16_q ? {ecx_hi_q, cnt16_dec} : cnt_dec;
    wb_size    = a16_q ? 3'd1 : 3'd3;
    case (state_q)
      S_IDLE: begin
        if (rep_none) begin
          out_valid  = in_valid & ~flush;
          in_ready   = out_ready | ~in_valid;
          out_opcode = in_opcode;
          out_last   = in_valid;
        end else begin
          in_ready = 1'b1;
        end
      end
      S_ITER: begin
        // An accept beats the yield: yield only when downstream is stalled.
        yield     = ~flush & pending_int & burst_sat & ~out_ready;
        int_yield = yield;
        out_valid = ~flush & ~yield;
        out_last  = cnt_last & out_valid;
        hold_int  = ~burst_sat;
        wb_valid  = out_valid & out_ready;
      end
      S_WAIT_ZF: hold_int = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, latched instruction and iteration counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      repne_q  <= 1'b0;
      a16_q    <= 1'b0;
      ecx_hi_q <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      burst_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rep_none && in_valid) begin
            opc_q    <= in_opcode;
            repne_q  <= in_rep == 2'b10;
            a16_q    <= in_addr16;
            ecx_hi_q <= ecx_in[CNT_W-1:16];
            cnt_q    <= in_cnt;
            burst_q  <= '0;
            state_q  <= (in_cnt != '0) ? S_ITER : S_IDLE;
          end
        end
        S_ITER: begin
          if (fire) begin
            cnt_q <= cnt_dec;
            if (!burst_sat) burst_q <= burst_q + 4'd1;
            if (cnt_last)     state_q <= S_IDLE;
            else if (cond_op) state_q <= S_WAIT_ZF;
          end else if (yield) begin
            burst_q <= '0;
            state_q <= S_IDLE;
          end
        end
        S_WAIT_ZF: begin
          if (flag_valid) state_q <= zf_term ? S_IDLE : S_ITER;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
